// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared widths and constants for the RV32I register file and scoreboard
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int CNT_W      = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rv32i_sb_counter.sv
// rtl/rv32i_sb_counter.sv - saturating up/down pending-write counter for one register
module rv32i_sb_counter
  import rv32i_pkg::*;
#(
  parameter int CNT_W = rv32i_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // inc and dec together cancel; the ends of the range hold instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != CNT_MAX) count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - CNT_W'(1);
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/rv32i_regfile_sb.sv
// rtl/rv32i_regfile_sb.sv - RV32I register file with write bypass and pending-write scoreboard
module rv32i_regfile_sb
  import rv32i_pkg::*;
#(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int NREG  = rv32i_pkg::NREG,
  parameter int CNT_W = rv32i_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en_in,
  input  logic [REG_ADDR_W-1:0] wb_reg_in,
  input  logic [XLEN-1:0]       wb_data_in,
  input  logic [REG_ADDR_W-1:0] rs1_reg,
  input  logic [REG_ADDR_W-1:0] rs2_reg,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  flush,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  stall,
  output logic [NREG-1:0]       pending_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  regs [NREG];
  logic [CNT_W-1:0] cnt  [NREG];

  logic wb_hit_rs1, wb_hit_rs2;
  logic src_block1, src_block2, dst_full;
  logic issue_acc;

  // x0 is reset like the rest but never written afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en_in && wb_reg_in != REG_ZERO) begin
      regs[wb_reg_in] <= wb_data_in;
    end
  end

  assign wb_hit_rs1 = wb_en_in && (wb_reg_in == rs1_reg) && (rs1_reg != REG_ZERO);
  assign wb_hit_rs2 = wb_en_in && (wb_reg_in == rs2_reg) && (rs2_reg != REG_ZERO);

  always_comb begin
    rs1_data = regs[rs1_reg];
    if (rs1_reg == REG_ZERO) rs1_data = '0;
    else if (wb_hit_rs1)     rs1_data = wb_data_in;
  end

  always_comb begin
    rs2_data = regs[rs2_reg];
    if (rs2_reg == REG_ZERO) rs2_data = '0;
    else if (wb_hit_rs2)     rs2_data = wb_data_in;
  end

  // a landing write that is the only one outstanding is forwarded, so it does not block
  assign src_block1 = rs1_used && (rs1_reg != REG_ZERO) && (cnt[rs1_reg] != '0)
                      && !(wb_hit_rs1 && cnt[rs1_reg] == CNT_ONE);
  assign src_block2 = rs2_used && (rs2_reg != REG_ZERO) && (cnt[rs2_reg] != '0)
                      && !(wb_hit_rs2 && cnt[rs2_reg] == CNT_ONE);
  assign dst_full   = issue_valid && issue_wb_en && (issue_rd != REG_ZERO)
                      && (cnt[issue_rd] == CNT_MAX);

  assign stall     = issue_valid && !flush && (src_block1 || src_block2 || dst_full);
  assign issue_acc = issue_valid && issue_wb_en && (issue_rd != REG_ZERO) && !stall && !flush;

  assign cnt[0]          = '0;
  assign pending_mask[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic inc_r, dec_r;

    assign inc_r = issue_acc && (issue_rd == REG_ADDR_W'(r));
    assign dec_r = wb_en_in && (wb_reg_in == REG_ADDR_W'(r));

    rv32i_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc_r),
      .dec     (dec_r),
      .clr     (flush),
      .count   (cnt[r]),
      .nonzero (pending_mask[r])
    );
  end

endmodule

// File: doc/rv32i_regfile_sb.md
Name: rv32i_regfile_sb

Overview:
- Register-file end of the writeback interface: consumes the writeback enable, register and data from the writeback stage and serves two decode read ports with same-cycle write bypass.
- Integrates a per-register pending-write scoreboard. Decode marks destinations on issue, writeback retires them, and a stall is raised while a source operand's value is still in flight.
- Sits between the decode stage and the writeback stage of the RV32I pipeline.

Parameters:
XLEN, 32, data width of each architectural register
NREG, 32, number of architectural registers; x0 hardwired to zero
CNT_W, 3, width of each scoreboard counter (max in-flight writes per register = 2^CNT_W-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wb_en_in  in  1  writeback enable from writeback stage
wb_reg_in  in  5  writeback destination register
wb_data_in  in  XLEN  writeback data
rs1_reg  in  5  decode source register 1
rs2_reg  in  5  decode source register 2
rs1_used  in  1  instruction in decode reads rs1
rs2_used  in  1  instruction in decode reads rs2
issue_valid  in  1  decode presents an instruction for issue this cycle
issue_wb_en  in  1  issuing instruction writes a register
issue_rd  in  5  issuing instruction destination
flush  in  1  pipeline flush (taken branch/jump); clears scoreboard
rs1_data  out  XLEN  source 1 operand (combinational)
rs2_data  out  XLEN  source 2 operand (combinational)
stall  out  1  decode must hold; instruction not issued (combinational)
pending_mask  out  NREG  bit i = counter i non-zero (registered view)

Behaviour:
- Reset (async, active-high): all registers = 0, all counters = 0, pending_mask = 0. While reset is high, writes and issues are ignored.
- Write: at posedge clk, if wb_en_in and wb_reg_in != 0, then reg[wb_reg_in] <= wb_data_in. Writes to x0 are dropped.
- Read: rsN_data = 0 if rsN_reg == 0.
- Bypass: else if wb_en_in and wb_reg_in == rsN_reg, rsN_data = wb_data_in (zero-latency bypass).
- Otherwise rsN_data = reg[rsN_reg].
- wb_hit(r) = wb_en_in and wb_reg_in == r and r != 0.
- src_block(N) = rsN_used and rsN_reg != 0 and cnt[rsN_reg] != 0 and not (wb_hit(rsN_reg) and cnt[rsN_reg] == 1).
  - A landing write that is the last outstanding write for that register unblocks through the bypass.
  - If cnt > 1, a younger write is still in flight, so the source stays blocked.
- dst_full = issue_valid and issue_wb_en and issue_rd != 0 and cnt[issue_rd] == max.
- stall = issue_valid and not flush and (src_block(1) or src_block(2) or dst_full).
- issue_acc = issue_valid and issue_wb_en and issue_rd != 0 and not stall and not flush.
- Counter update per register r at posedge:
  - flush: cnt = 0 for all r; flush overrides issue and retire.
  - issue_acc to r and wb_hit(r) in the same cycle: cnt unchanged.
  - issue_acc to r only: cnt + 1.
  - wb_hit(r) only: cnt - 1 if cnt > 0. At 0 the retire is ignored; this covers writes that were in flight across a flush.
- pending_mask is registered: it reflects the counters after each edge.
- Writes to the register file itself are never suppressed by flush. Squashing wrong-path writeback is the writeback stage's job, done via wb_en_in.
- Latency:
  - Reads and stall are combinational.
  - Scoreboard state is visible on the cycle after issue or retire.

Decomposition:
- Shared package rv32i_pkg holds XLEN, REG_ADDR_W = 5, NREG, CNT_W, and the constant REG_ZERO = 5'd0.
- One natural sub-module is rv32i_sb_counter: a single saturating up/down counter with inc, dec, clr, count and nonzero. It is instantiated NREG-1 times (x1..x31); x0 has no counter.
- Register array and bypass muxing live in the top.

Test Plan:
- Reset then read: assert reset mid-run after writing x5 = 0x1234 → rs1_data(x5) = 0 immediately (async); pending_mask = 0.
- x0: wb_en_in = 1, wb_reg_in = 0, wb_data_in = 0xFFFFFFFF → rs1_data(x0) = 0 that cycle and after; issue_rd = 0 does not set pending_mask.
- Bypass: wb x7 = 0xDEADBEEF while rs2_reg = 7 in the same cycle → rs2_data = 0xDEADBEEF before the edge; reg[7] holds it after the edge.
- RAW stall: issue to x3 (count 1), next cycle decode reads x3 → stall = 1 until wb_hit(x3); on the wb cycle stall = 0 and rs1_data = wb data. Two issues to x3 then one wb → stall remains 1.
- Simultaneous issue and retire on x9 with cnt = 1 → cnt stays 1 and pending_mask[9] = 1. Issue 7 writes to x4 without retire → the 8th issue stalls with dst_full.
- Flush: pending x2, x6 plus flush and issue_valid → stall = 0, no issue accepted, pending_mask = 0 next cycle; a later wb to x2 leaves cnt at 0.
